// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai222_bist_pkg.sv
// +--------------------------------------------------------------------------+
// | Module : gf180mcu_fd_sc_mcu9t5v0__oai222_bist_pkg                        |
// | Brief  : Shared state encoding, vector constants and golden OAI222 model |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package gf180mcu_fd_sc_mcu9t5v0__oai222_bist_pkg;

    localparam int VEC_W = 6;
    localparam logic [VEC_W-1:0] LAST_VEC = 6'd63;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    // Vector bit order is {C2,C1,B2,B1,A2,A1}.
    function automatic logic oai222_golden(input logic [VEC_W-1:0] vec);
        return ~((vec[0] | vec[1]) & (vec[2] | vec[3]) & (vec[4] | vec[5]));
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai222_bist_chk.sv
// +--------------------------------------------------------------------------+
// | Module : gf180mcu_fd_sc_mcu9t5v0__oai222_bist_chk                        |
// | Brief  : ZN comparator, saturating error counter, first-fail capture     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__oai222_bist_chk
    import gf180mcu_fd_sc_mcu9t5v0__oai222_bist_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_sample,
    input  logic             i_inject,
    input  logic [VEC_W-1:0] i_vec,
    input  logic             i_zn,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_fail_vld,
    output logic [VEC_W-1:0] o_fail_vec
);

    logic [ERR_W-1:0] r_err_cnt;
    logic             r_fail_vld;
    logic [VEC_W-1:0] r_fail_vec;
    logic             w_mismatch;

    assign w_mismatch = i_zn != (oai222_golden(i_vec) ^ i_inject);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_err_cnt  <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
        end else if (i_sample && w_mismatch) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            // Only the first failing vector is kept.
            if (!r_fail_vld) begin
                r_fail_vld <= 1'b1;
                r_fail_vec <= i_vec;
            end
        end
    end

    assign o_err_cnt  = r_err_cnt;
    assign o_fail_vld = r_fail_vld;
    assign o_fail_vec = r_fail_vec;

endmodule

`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai222_bist.sv
// +--------------------------------------------------------------------------+
// | Module : gf180mcu_fd_sc_mcu9t5v0__oai222_bist                            |
// | Brief  : BIST sequencer sweeping all 64 OAI222 input vectors and         |
// |          checking ZN. Optional INJECT port: define                       |
// |          GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module gf180mcu_fd_sc_mcu9t5v0__oai222_bist
    import gf180mcu_fd_sc_mcu9t5v0__oai222_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
    input  logic             INJECT,
`endif
    output logic             A1,
    output logic             A2,
    output logic             B1,
    output logic             B2,
    output logic             C1,
    output logic             C2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VLD,
    output logic [VEC_W-1:0] FAIL_VEC
);

    localparam bist_state_t c_FIRST       = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
    localparam logic [3:0]  c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  c_PASS_LAST   = 8'(NUM_PASSES - 1);

    bist_state_t      r_state;
    logic [VEC_W-1:0] r_vec;
    logic [7:0]       r_pass_cnt;
    logic [3:0]       r_settle_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_start_ok;
    logic             w_sample;
    logic             w_inject;
    logic [ERR_W-1:0] w_err_cnt;

`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
    assign w_inject = INJECT;
`else
    assign w_inject = 1'b0;
`endif

    assign w_start_ok = START && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_sample   = (r_state == ST_SAMPLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_pass_cnt   <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_start_ok) begin
            r_state      <= c_FIRST;
            r_vec        <= '0;
            r_pass_cnt   <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_settle_cnt <= '0;
                        r_state      <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_vec != LAST_VEC) begin
                        r_vec   <= r_vec + 1'b1;
                        r_state <= c_FIRST;
                    end else if (r_pass_cnt < c_PASS_LAST) begin
                        r_vec      <= '0;
                        r_pass_cnt <= r_pass_cnt + 1'b1;
                        r_state    <= c_FIRST;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                // Flags update one cycle after the last sample so PASS sees the final count.
                ST_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= (w_err_cnt == '0);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    gf180mcu_fd_sc_mcu9t5v0__oai222_bist_chk #(
        .ERR_W (ERR_W)
    ) u_chk (
        .clk        (CLK),
        .rst        (RST),
        .i_clear    (w_start_ok),
        .i_sample   (w_sample),
        .i_inject   (w_inject),
        .i_vec      (r_vec),
        .i_zn       (ZN),
        .o_err_cnt  (w_err_cnt),
        .o_fail_vld (FAIL_VLD),
        .o_fail_vec (FAIL_VEC)
    );

    assign {C2, C1, B2, B1, A2, A1} = r_vec;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign PASS    = r_pass;
    assign ERR_CNT = w_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__oai222_bist.sv
// +--------------------------------------------------------------------------+
// | Module : tb_gf180mcu_fd_sc_mcu9t5v0__oai222_bist                         |
// | Brief  : Directed self-checking bench for the OAI222 BIST sequencer      |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_gf180mcu_fd_sc_mcu9t5v0__oai222_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic start = 1'b0;
    int   zn_mode = 0;  // 0 correct cell, 1 stuck at 0, 2 stuck at 1
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   d[4];

    function automatic logic ref_zn(input logic [5:0] v, input int mode);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return !((v[0] || v[1]) && (v[2] || v[3]) && (v[4] || v[5]));
    endfunction

    // Instance 0 default, 1 SETTLE_CYCLES=0, 2 ERR_W=4, 3 NUM_PASSES=2.
    wire [5:0] v0, v1, v2, v3;
    wire       zn0, zn1, zn2, zn3;
    wire       busy0, busy1, busy2, busy3;
    wire       done0, done1, done2, done3;
    wire       pass0, pass1, pass2, pass3;
    wire [7:0] err0, err1, err3;
    wire [3:0] err2;
    wire       vld0, vld1, vld2, vld3;
    wire [5:0] fv0, fv1, fv2, fv3;

    assign zn0 = ref_zn(v0, zn_mode);
    assign zn1 = ref_zn(v1, zn_mode);
    assign zn2 = ref_zn(v2, zn_mode);
    assign zn3 = ref_zn(v3, zn_mode);

`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
    logic inject = 1'b0;
`endif

    gf180mcu_fd_sc_mcu9t5v0__oai222_bist dut (
        .CLK(clk), .RST(rst), .START(start), .ZN(zn0),
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
        .INJECT(inject),
`endif
        .A1(v0[0]), .A2(v0[1]), .B1(v0[2]), .B2(v0[3]), .C1(v0[4]), .C2(v0[5]),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0),
        .FAIL_VLD(vld0), .FAIL_VEC(fv0)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai222_bist #(.SETTLE_CYCLES(0)) dut_s0 (
        .CLK(clk), .RST(rst), .START(start), .ZN(zn1),
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
        .INJECT(1'b0),
`endif
        .A1(v1[0]), .A2(v1[1]), .B1(v1[2]), .B2(v1[3]), .C1(v1[4]), .C2(v1[5]),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
        .FAIL_VLD(vld1), .FAIL_VEC(fv1)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai222_bist #(.ERR_W(4)) dut_e4 (
        .CLK(clk), .RST(rst), .START(start), .ZN(zn2),
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
        .INJECT(1'b0),
`endif
        .A1(v2[0]), .A2(v2[1]), .B1(v2[2]), .B2(v2[3]), .C1(v2[4]), .C2(v2[5]),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .ERR_CNT(err2),
        .FAIL_VLD(vld2), .FAIL_VEC(fv2)
    );

    gf180mcu_fd_sc_mcu9t5v0__oai222_bist #(.NUM_PASSES(2)) dut_p2 (
        .CLK(clk), .RST(rst), .START(start), .ZN(zn3),
`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
        .INJECT(1'b0),
`endif
        .A1(v3[0]), .A2(v3[1]), .B1(v3[2]), .B2(v3[3]), .C1(v3[4]), .C2(v3[5]),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3),
        .FAIL_VLD(vld3), .FAIL_VEC(fv3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses START, optionally re-pulses START or RST at a given cycle, and
    // records the first cycle each instance shows DONE (0 = never, 300-cycle bound).
    task automatic run(input int again_at, input int rst_at);
        for (int i = 0; i < 4; i++) d[i] = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_done_drop", {31'd0, done0}, 32'd0);
        check("start_busy", {31'd0, busy0}, 32'd1);
        for (int c = 1; c <= 300; c++) begin
            if (c == again_at) start = 1'b1;
            if (c == rst_at)   rst   = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
            if (c == rst_at) begin
                check("rst_outputs_zero", {8'd0, v0, busy0, done0, pass0, err0, vld0, fv0}, 32'd0);
                check("rst_busy_p2", {31'd0, busy3}, 32'd0);
            end
            if (d[0] == 0 && done0) d[0] = c;
            if (d[1] == 0 && done1) d[1] = c;
            if (d[2] == 0 && done2) d[2] = c;
            if (d[3] == 0 && done3) d[3] = c;
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", {8'd0, v0, busy0, done0, pass0, err0, vld0, fv0}, 32'd0);
        rst = 1'b0;

        // Correct cell; mid-run START at cycle 20 must be ignored.
        zn_mode = 0;
        run(20, 0);
        check("good_latency", 32'(d[0]), 32'd129);
        check("good_pass", {31'd0, pass0}, 32'd1);
        check("good_err", {24'd0, err0}, 32'd0);
        check("good_fail_vld", {31'd0, vld0}, 32'd0);
        check("good_busy_low", {31'd0, busy0}, 32'd0);
        check("done_holds_vec63", {26'd0, v0}, 32'd63);
        check("s0_latency", 32'(d[1]), 32'd65);
        check("s0_pass", {31'd0, pass1}, 32'd1);
        check("p2_latency", 32'(d[3]), 32'd257);
        check("p2_pass", {31'd0, pass3}, 32'd1);

        // ZN stuck at 0: every vector with golden 1 fails.
        zn_mode = 1;
        run(0, 0);
        check("sa0_latency", 32'(d[0]), 32'd129);
        check("sa0_err", {24'd0, err0}, 32'd37);
        check("sa0_fail_vld", {31'd0, vld0}, 32'd1);
        check("sa0_fail_vec", {26'd0, fv0}, 32'd0);
        check("sa0_pass", {31'd0, pass0}, 32'd0);
        check("sa0_done", {31'd0, done0}, 32'd1);
        check("e4_saturate", {28'd0, err2}, 32'd15);
        check("p2_sa0_err", {24'd0, err3}, 32'd74);

        // ZN stuck at 1: only the 27 all-pairs-active vectors fail.
        zn_mode = 2;
        run(0, 0);
        check("sa1_err", {24'd0, err0}, 32'd27);
        check("sa1_fail_vec", {26'd0, fv0}, 32'd21);
        check("sa1_s0_err", {24'd0, err1}, 32'd27);
        check("sa1_s0_fail_vec", {26'd0, fv1}, 32'd21);

        // RST at cycle 50 aborts the run; no DONE afterwards.
        zn_mode = 0;
        run(0, 50);
        check("abort_no_done", 32'(d[0]), 32'd0);
        check("abort_no_done_p2", 32'(d[3]), 32'd0);

        run(0, 0);
        check("restart_latency", 32'(d[0]), 32'd129);
        check("restart_pass", {31'd0, pass0}, 32'd1);
        check("restart_err", {24'd0, err0}, 32'd0);

`ifdef GF180MCU_FD_SC_MCU9T5V0__OAI222_BIST_INJECT_EN
        // Vector k is sampled at edge 2k+2 after START; vector 5 at edge 12.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            inject = (c == 12);
            @(posedge clk); #1;
            inject = 1'b0;
        end
        check("inject_err", {24'd0, err0}, 32'd1);
        check("inject_fail_vec", {26'd0, fv0}, 32'd5);
        check("inject_fail_vld", {31'd0, vld0}, 32'd1);
        check("inject_pass", {31'd0, pass0}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
